// File: rtl/ysyx_22041752_trap_seq.sv
// EX-stage trap/return sequencer: arbitrates interrupts, exceptions and mret,
// walks the CSR write port through the trap/return updates, then redirects fetch.
//
// state    | meaning
// IDLE     | waiting for an event on a valid EX instruction
// W_MEPC   | writing mepc with the trapping pc
// W_MCAUSE | writing mcause {is_irq, code}
// W_MTVAL  | writing mtval
// W_MSTAT  | writing mstatus (MIE -> MPIE, MIE cleared, MPP = M)
// W_MRET   | writing mstatus for mret (MPIE -> MIE, MPIE set, MPP = M)
// REDIR    | one-cycle flush pulse to the latched target
module ysyx_22041752_trap_seq #(
  parameter int XLEN        = 64,
  parameter int PC_WD       = 32,
  parameter int NUM_IRQ     = 2,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [PC_WD-1:0]   req_pc,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               mret_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] mie_i,
  input  logic [XLEN-1:0]    mstatus_i,
  input  logic [XLEN-1:0]    mtvec_i,
  input  logic [XLEN-1:0]    mepc_i,
  output logic               busy,
  output logic               csr_we,
  output logic [11:0]        csr_waddr,
  output logic [XLEN-1:0]    csr_wdata,
  output logic               flush,
  output logic [PC_WD-1:0]   flush_pc,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_MEPC   = 3'd1,
    W_MCAUSE = 3'd2,
    W_MTVAL  = 3'd3,
    W_MSTAT  = 3'd4,
    W_MRET   = 3'd5,
    REDIR    = 3'd6
  } state_t;

  state_t state, state_nxt;

  // armed keeps every output low during the first cycle after reset release
  logic armed;

  logic               is_irq_q;
  logic [4:0]         code_q;
  logic [XLEN-1:0]    tval_q;
  logic [PC_WD-1:0]   pc_q;
  logic [PC_WD-1:0]   target_q;

  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] win_onehot;
  logic               irq_any;
  logic [4:0]         irq_code;
  logic [4:0]         code_sel;
  logic               accept;
  logic               vec_mode;
  logic [XLEN-1:0]    trap_base;
  logic [XLEN-1:0]    trap_sum;
  logic [PC_WD-1:0]   target_nxt;
  logic [XLEN-1:0]    mstat_trap;
  logic [XLEN-1:0]    mstat_ret;
  logic               unused;

  function automatic logic [4:0] line_code(input int k);
    if (k == 0)      return 5'd11;
    else if (k == 1) return 5'd7;
    else             return 5'(14 + k);
  endfunction

  // descending scan so the lowest pending index is the one left standing
  always_comb begin
    pend       = irq_i & mie_i & {NUM_IRQ{mstatus_i[3]}};
    irq_any    = |pend;
    win_onehot = '0;
    irq_code   = 5'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pend[k]) begin
        win_onehot    = '0;
        win_onehot[k] = 1'b1;
        irq_code      = line_code(k);
      end
    end
  end

  assign accept    = armed && (state == IDLE) && req_valid && (irq_any || exc_valid || mret_i);
  assign code_sel  = irq_any ? irq_code : exc_code;
  assign vec_mode  = irq_any && VECTORED_EN && (mtvec_i[1:0] == 2'b01);
  assign trap_base = {mtvec_i[XLEN-1:2], 2'b00};
  assign trap_sum  = trap_base + (vec_mode ? (XLEN'(code_sel) << 2) : '0);
  assign target_nxt = (irq_any || exc_valid) ? trap_sum[PC_WD-1:0] : mepc_i[PC_WD-1:0];

  assign mstat_trap = {mstatus_i[XLEN-1:13], 2'b11, mstatus_i[10:8], mstatus_i[3],
                       mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
  assign mstat_ret  = {mstatus_i[XLEN-1:13], 2'b11, mstatus_i[10:8], 1'b1,
                       mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};

  assign unused = ^{mepc_i[XLEN-1:PC_WD], trap_sum[XLEN-1:PC_WD]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_irq_q <= 1'b0;
      code_q   <= '0;
      tval_q   <= '0;
      pc_q     <= '0;
      target_q <= '0;
    end else if (accept) begin
      is_irq_q <= irq_any;
      code_q   <= code_sel;
      tval_q   <= irq_any ? '0 : exc_tval;
      pc_q     <= req_pc;
      target_q <= target_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = (irq_any || exc_valid) ? W_MEPC : W_MRET;
      W_MEPC:   state_nxt = W_MCAUSE;
      W_MCAUSE: state_nxt = W_MTVAL;
      W_MTVAL:  state_nxt = W_MSTAT;
      W_MSTAT:  state_nxt = REDIR;
      W_MRET:   state_nxt = REDIR;
      REDIR:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    csr_we    = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    flush     = 1'b0;
    flush_pc  = '0;
    irq_ack   = '0;
    case (state)
      IDLE: begin
        busy    = accept;
        irq_ack = (accept && irq_any) ? win_onehot : '0;
      end
      W_MEPC: begin
        busy      = 1'b1;
        csr_we    = 1'b1;
        csr_waddr = ADDR_MEPC;
        csr_wdata = XLEN'(pc_q);
      end
      W_MCAUSE: begin
        busy      = 1'b1;
        csr_we    = 1'b1;
        csr_waddr = ADDR_MCAUSE;
        csr_wdata = {is_irq_q, {(XLEN-6){1'b0}}, code_q};
      end
      W_MTVAL: begin
        busy      = 1'b1;
        csr_we    = 1'b1;
        csr_waddr = ADDR_MTVAL;
        csr_wdata = tval_q;
      end
      W_MSTAT: begin
        busy      = 1'b1;
        csr_we    = 1'b1;
        csr_waddr = ADDR_MSTATUS;
        csr_wdata = mstat_trap;
      end
      W_MRET: begin
        busy      = 1'b1;
        csr_we    = 1'b1;
        csr_waddr = ADDR_MSTATUS;
        csr_wdata = mstat_ret;
      end
      REDIR: begin
        flush    = 1'b1;
        flush_pc = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041752_trap_seq.sv
// Directed bench for the trap/return sequencer: reset, ecall, vectored timer,
// arbitration, masked-irq exception, mret and mid-sequence reset.
module tb_ysyx_22041752_trap_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [63:0] exc_tval;
  logic        mret_i;
  logic [1:0]  irq_i;
  logic [1:0]  mie_i;
  logic [63:0] mstatus_i;
  logic [63:0] mtvec_i;
  logic [63:0] mepc_i;
  logic        busy;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic [1:0]  irq_ack;

  int checks = 0;
  int failures = 0;

  ysyx_22041752_trap_seq #(
    .XLEN(64), .PC_WD(32), .NUM_IRQ(2), .VECTORED_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_pc(req_pc),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval),
    .mret_i(mret_i), .irq_i(irq_i), .mie_i(mie_i), .mstatus_i(mstatus_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .busy(busy), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .flush(flush),
    .flush_pc(flush_pc), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s_busy", tag), 64'(busy), 64'd0);
    check($sformatf("%s_we", tag), 64'(csr_we), 64'd0);
    check($sformatf("%s_waddr", tag), 64'(csr_waddr), 64'd0);
    check($sformatf("%s_wdata", tag), csr_wdata, 64'd0);
    check($sformatf("%s_flush", tag), 64'(flush), 64'd0);
    check($sformatf("%s_flush_pc", tag), 64'(flush_pc), 64'd0);
    check($sformatf("%s_irq_ack", tag), 64'(irq_ack), 64'd0);
  endtask

  task automatic accept_checks(input string tag, input logic [1:0] ack_exp);
    check($sformatf("%s_acc_busy", tag), 64'(busy), 64'd1);
    check($sformatf("%s_acc_ack", tag), 64'(irq_ack), 64'(ack_exp));
    check($sformatf("%s_acc_we", tag), 64'(csr_we), 64'd0);
    check($sformatf("%s_acc_flush", tag), 64'(flush), 64'd0);
  endtask

  // Steps from the accept edge through REDIR; inputs are scrambled after
  // accept to show the sequence runs on latched values only.
  task automatic trap_seq(input string tag, input logic [31:0] pc, input logic [63:0] cause,
                          input logic [63:0] tval, input logic [63:0] mstat_exp,
                          input logic [31:0] target);
    tick();
    exc_valid = 1'b0; mret_i = 1'b0; irq_i = 2'b00;
    req_pc = 32'hFFFF_FFF0; exc_tval = '1; exc_code = 5'd3;
    #1;
    check($sformatf("%s_mepc_we", tag), 64'(csr_we), 64'd1);
    check($sformatf("%s_mepc_addr", tag), 64'(csr_waddr), 64'h341);
    check($sformatf("%s_mepc_data", tag), csr_wdata, 64'(pc));
    check($sformatf("%s_mepc_busy", tag), 64'(busy), 64'd1);
    check($sformatf("%s_ack_gone", tag), 64'(irq_ack), 64'd0);
    tick();
    check($sformatf("%s_mcause_addr", tag), 64'(csr_waddr), 64'h342);
    check($sformatf("%s_mcause_data", tag), csr_wdata, cause);
    check($sformatf("%s_mcause_busy", tag), 64'(busy), 64'd1);
    tick();
    check($sformatf("%s_mtval_addr", tag), 64'(csr_waddr), 64'h343);
    check($sformatf("%s_mtval_data", tag), csr_wdata, tval);
    check($sformatf("%s_mtval_busy", tag), 64'(busy), 64'd1);
    tick();
    check($sformatf("%s_mstat_addr", tag), 64'(csr_waddr), 64'h300);
    check($sformatf("%s_mstat_data", tag), csr_wdata, mstat_exp);
    check($sformatf("%s_mstat_busy", tag), 64'(busy), 64'd1);
    check($sformatf("%s_mstat_flush", tag), 64'(flush), 64'd0);
    tick();
    check($sformatf("%s_redir_flush", tag), 64'(flush), 64'd1);
    check($sformatf("%s_redir_pc", tag), 64'(flush_pc), 64'(target));
    check($sformatf("%s_redir_busy", tag), 64'(busy), 64'd0);
    check($sformatf("%s_redir_we", tag), 64'(csr_we), 64'd0);
    tick();
    check($sformatf("%s_after_flush", tag), 64'(flush), 64'd0);
    check($sformatf("%s_after_busy", tag), 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b1; req_pc = 32'h8000_0000;
    exc_valid = 1'b1; exc_code = 5'd11; exc_tval = 64'h55; mret_i = 1'b1;
    irq_i = 2'b11; mie_i = 2'b11; mstatus_i = 64'h8;
    mtvec_i = 64'h8000_0004; mepc_i = 64'h8000_0200;
    repeat (3) tick();
    check_zero("rst_hold");
    reset = 1'b1;
    #1;
    check_zero("rst_first");
    req_valid = 1'b0; irq_i = 2'b00; exc_valid = 1'b0; mret_i = 1'b0;
    tick();
    check_zero("idle");

    // ecall
    req_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd11; exc_tval = 64'd0;
    req_pc = 32'h8000_0100; mtvec_i = 64'h8000_0004; mstatus_i = 64'h8;
    #1;
    accept_checks("ecall", 2'b00);
    trap_seq("ecall", 32'h8000_0100, 64'hb, 64'd0, 64'h1880, 32'h8000_0004);
    req_valid = 1'b0;

    // vectored timer, irq drops right after accept
    req_valid = 1'b1; irq_i = 2'b10; mie_i = 2'b11; mstatus_i = 64'h8;
    mtvec_i = 64'h8000_1001; req_pc = 32'h8000_0200;
    #1;
    accept_checks("timer", 2'b10);
    trap_seq("timer", 32'h8000_0200, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, 32'h8000_101C);
    req_valid = 1'b0;

    // irq beats exception and mret; line 0 wins
    req_valid = 1'b1; irq_i = 2'b11; exc_valid = 1'b1; exc_code = 5'd2;
    exc_tval = 64'hDEAD; mret_i = 1'b1; req_pc = 32'h8000_0300;
    #1;
    accept_checks("arb", 2'b01);
    trap_seq("arb", 32'h8000_0300, 64'h8000_0000_0000_000B, 64'd0, 64'h1880, 32'h8000_102C);
    req_valid = 1'b0;

    // MIE=0 masks irqs; exception not vectored even in vectored mode
    req_valid = 1'b1; mstatus_i = 64'h0; irq_i = 2'b11; exc_valid = 1'b1;
    exc_code = 5'd2; exc_tval = 64'hDEAD_BEEF_0000_1234; req_pc = 32'h8000_0400;
    #1;
    accept_checks("exc", 2'b00);
    trap_seq("exc", 32'h8000_0400, 64'h2, 64'hDEAD_BEEF_0000_1234, 64'h1800, 32'h8000_1000);
    req_valid = 1'b0;

    // pending irq without a valid instruction is not accepted
    mstatus_i = 64'h8; irq_i = 2'b01;
    #1;
    check("novalid_busy", 64'(busy), 64'd0);
    check("novalid_ack", 64'(irq_ack), 64'd0);
    tick();
    check("novalid_we", 64'(csr_we), 64'd0);
    irq_i = 2'b00;

    // mret
    req_valid = 1'b1; mret_i = 1'b1; mstatus_i = 64'h80; mepc_i = 64'h8000_0200;
    #1;
    accept_checks("mret", 2'b00);
    tick();
    mret_i = 1'b0; mepc_i = 64'h1111_0000;
    #1;
    check("mret_we", 64'(csr_we), 64'd1);
    check("mret_addr", 64'(csr_waddr), 64'h300);
    check("mret_data", csr_wdata, 64'h1888);
    check("mret_busy", 64'(busy), 64'd1);
    tick();
    check("mret_flush", 64'(flush), 64'd1);
    check("mret_pc", 64'(flush_pc), 64'h8000_0200);
    check("mret_redir_busy", 64'(busy), 64'd0);
    tick();
    check("mret_after_flush", 64'(flush), 64'd0);
    req_valid = 1'b0;

    // reset pulsed in W_MCAUSE
    mstatus_i = 64'h8; mtvec_i = 64'h8000_0004;
    req_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd11; req_pc = 32'h8000_0500;
    #1;
    accept_checks("midrst", 2'b00);
    tick();
    req_valid = 1'b0; exc_valid = 1'b0;
    tick();
    check("midrst_pre_we", 64'(csr_we), 64'd1);
    check("midrst_pre_addr", 64'(csr_waddr), 64'h342);
    reset = 1'b0;
    #1;
    check_zero("midrst_hold");
    tick();
    check_zero("midrst_hold2");
    reset = 1'b1;
    #1;
    check_zero("midrst_rel");
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("midrst_we_%0d", i), 64'(csr_we), 64'd0);
      check($sformatf("midrst_flush_%0d", i), 64'(flush), 64'd0);
      check($sformatf("midrst_busy_%0d", i), 64'(busy), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
